// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 32-bit Galois PRBS stream, with lock tracking and error counters.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] word_err_count,
  output logic [CNT_W-1:0] bit_err_count
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [31:0] expected, expected_n;
  logic [3:0] run, run_n, run_inc;
  logic err_n, match;
  logic [5:0] pop;
  logic [CNT_W:0] bit_sum;
  logic [CNT_W-1:0] word_n, bit_n;
  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31]} ^ ({32{s[31]}} & 32'h0040_0006);
  endfunction
  assign locked = (state == LOCKED);
  always_comb begin
    state_n = state;
    expected_n = expected;
    run_n = run;
    err_n = 1'b0;
    match = (in_data == expected);
    run_inc = run + 4'd1;
    pop = 6'($countones(in_data ^ expected));
    bit_sum = {1'b0, bit_err_count} + {{(CNT_W-5){1'b0}}, pop};
    if (in_valid)
      case (state)
        HUNT:
          if (in_data != '0) begin
            expected_n = step(in_data);
            run_n = '0;
            state_n = VERIFY;
          end
        VERIFY:
          if (match) begin
            expected_n = step(in_data);
            run_n = (run_inc == 4'(LOCK_CNT)) ? '0 : run_inc;
            state_n = (run_inc == 4'(LOCK_CNT)) ? LOCKED : VERIFY;
          end else if (in_data != '0) begin
            expected_n = step(in_data);
            run_n = '0;
          end else
            state_n = HUNT;
        LOCKED: begin
          // flywheel: prediction never reseeds from received data while locked
          expected_n = step(expected);
          err_n = !match;
          run_n = match ? '0 : (run_inc == 4'(LOSS_CNT)) ? '0 : run_inc;
          state_n = (!match && run_inc == 4'(LOSS_CNT)) ? HUNT : LOCKED;
        end
        default: state_n = HUNT;
      endcase
    word_n = clear_cnt ? '0 : (err_n && word_err_count != '1) ? word_err_count + 1'b1 : word_err_count;
    bit_n = clear_cnt ? '0 : !err_n ? bit_err_count : bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      expected <= '0;
      run <= '0;
      err_pulse <= 1'b0;
      word_err_count <= '0;
      bit_err_count <= '0;
    end else begin
      state <= state_n;
      expected <= expected_n;
      run <= run_n;
      err_pulse <= err_n;
      word_err_count <= word_n;
      bit_err_count <= bit_n;
    end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the 32-bit Galois PRBS stream produced by the `lfsr` generator. It self-synchronises to the incoming word stream and declares lock after a run of correctly predicted words. While locked, it flywheels its own predicted sequence and counts word and bit errors. It sits at the sink end of a PRBS link or loopback path, together with the generator, for datapath BIST.

## Interface
Parameters:
- `LOCK_CNT`, default 4: consecutive correctly predicted words needed to declare lock (1..15).
- `LOSS_CNT`, default 4: consecutive mismatched words, while locked, that drop lock (1..15).
- `CNT_W`, default 16: width of the error counters.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `in_data` is a new PRBS word this cycle.
- `in_data`, input, 32: received PRBS word.
- `clear_cnt`, input, 1: synchronous clear of both error counters.
- `locked`, output, 1: checker is in the LOCKED state.
- `err_pulse`, output, 1: one-cycle pulse for each mismatched word while locked.
- `word_err_count`, output, CNT_W: mismatched words seen while locked; saturating.
- `bit_err_count`, output, CNT_W: total mismatched bits seen while locked; saturating.

## Operation
- `step(s)` is the generator's next-state function, with f = s[31]:
  - n[0] = f
  - n[1] = s[0]^f
  - n[2] = s[1]^f
  - n[22] = s[21]^f
  - all other n[i] = s[i-1]
- Internal registers:
  - `expected`: 32-bit predicted next word.
  - `run`: 4-bit counter for the current match or miss run.
  - `state`: one of HUNT, VERIFY, LOCKED.
- When `in_valid`=0, all state, counters and `expected` hold.
- HUNT:
  - On a valid word, if `in_data`≠0: `expected`←step(in_data), `run`←0, go to VERIFY.
  - A zero word is the lockup state. It is ignored and the checker stays in HUNT.
- VERIFY:
  - Match (`in_data`==`expected`): `run`←run+1 and `expected`←step(in_data). If run+1==LOCK_CNT, go to LOCKED and set `run`←0.
  - Mismatch with `in_data`≠0: reseed (`expected`←step(in_data), `run`←0) and stay in VERIFY.
  - Mismatch with `in_data`==0: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED:
  - `expected`←step(expected) on every valid word (flywheel). The checker never reseeds from received data, so a corrupted word does not poison later predictions.
  - Match: `run`←0.
  - Mismatch:
    - `err_pulse` asserts.
    - `word_err_count` += 1.
    - `bit_err_count` += popcount(in_data ^ expected).
    - `run`←run+1.
    - If run+1==LOSS_CNT, go to HUNT and set `run`←0.
- Counters saturate at 2^CNT_W−1. For `bit_err_count`, the sum is clamped.
- `clear_cnt` zeroes both counters on the next edge. If an increment happens in the same cycle, clear wins and the result is 0.
- Counters are not cleared on loss of lock.

## Timing
- Reset values:
  - state HUNT
  - `locked`=0
  - `err_pulse`=0
  - both counters 0
  - `expected`=0
  - `run`=0
- All outputs are registered, with no combinational input-to-output path.
- `locked` rises on the edge that accepts the LOCK_CNT-th consecutive matching word. With continuous valid input that is the word after the seed, so lock is reached after LOCK_CNT+1 words.
- `locked` falls on the edge that accepts the LOSS_CNT-th consecutive mismatch. That final mismatch is still counted and pulsed.
- `err_pulse` is high for exactly one cycle, on the edge that accepts the bad word. The counters update on the same edge.
- Gaps in `in_valid` have no effect on run counters or prediction. The checker advances per word, not per clock.
- `rst` asserted mid-stream returns all outputs to their reset values immediately (asynchronous). After release, the checker resynchronises from HUNT.
- Worst-case popcount is 32, so it must fit within CNT_W ≥ 6.

## Test plan
- Lock: feed 0xFFFFFFFF, 0xFFBFFFF9, then successive step() values, `in_valid`=1 → `locked`=1 after the 5th word is accepted; both counters stay 0 and `err_pulse` never fires.
- Step check: the word after 0x80000000 is 0x00400007 and the word after 0x00000001 is 0x00000002 → these sequences lock; a deviation during VERIFY causes a reseed and `locked` stays 0.
- Single error while locked: flip bits 0 and 5 of one word → one `err_pulse`, `word_err_count`=1, `bit_err_count`=2; the next clean word matches and `locked` stays 1.
- Loss of lock: after lock, feed 4 consecutive random wrong words → `word_err_count`=4 and `locked` falls with the 4th; a subsequent clean stream relocks and the counters are retained.
- Edge cases:
  - All-zero words in HUNT are ignored, with state staying HUNT.
  - `clear_cnt` coincident with an error gives counters = 0.
  - With CNT_W=6, a stream of all-inverted words saturates `bit_err_count` at 63.
- Reset/gaps: randomly deassert `in_valid` while locked → no errors and lock is held. Assert `rst` mid-stream → `locked`, `err_pulse` and counters go to 0 before the next clock edge.
